bin2bcd_seq: RTL and testbench

//   Sequential, parametrised binary-to-BCD converter for the weight display path.

---
 rtl/bin2bcd_seq.sv | 116 +++++++++++
 tb/tb_bin2bcd_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, with
// range saturation, an overflow flag and a leading-zero blanking mask.
module bin2bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                ovf,
  output logic [DIGITS-1:0]   lz_mask
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + BIN_W;
  localparam int LW = (BIN_W > BW) ? BIN_W : BW;
  localparam int CW = $clog2(BIN_W + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  function automatic logic [LW-1:0] calc_limit(input int nd);
    logic [LW-1:0] p;
    p = LW'(1);
    for (int i = 0; i < nd; i++) p = p * LW'(10);
    return p - LW'(1);
  endfunction

  localparam logic [LW-1:0] LIMIT = calc_limit(DIGITS);
  localparam logic [BW-1:0] NINES = {DIGITS{4'h9}};

  // Add-3 on every BCD nibble >= 5 (no carry between nibbles), then shift left.
  function automatic logic [SW-1:0] dabble_step(input logic [SW-1:0] s);
    logic [SW-1:0] t;
    t = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (t[BIN_W+4*i +: 4] >= 4'd5) t[BIN_W+4*i +: 4] = t[BIN_W+4*i +: 4] + 4'd3;
    end
    return {t[SW-2:0], 1'b0};
  endfunction

  // Units digit is never blanked, so bit 0 stays 0.
  function automatic logic [DIGITS-1:0] blank_mask(input logic [BW-1:0] d);
    logic [DIGITS-1:0] m;
    logic              z;
    m = '0;
    z = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z    = z & (d[4*i +: 4] == 4'd0);
      m[i] = z;
    end
    return m;
  endfunction

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic          ovf_pend;
  logic [SW-1:0] sr;
  logic [SW-1:0] sr_next;
  logic [BW-1:0] final_bcd;
  logic          last;
  logic [LW-1:0] bin_ext;

  always_comb begin
    sr_next   = dabble_step(sr);
    final_bcd = ovf_pend ? NINES : sr_next[SW-1 -: BW];
    last      = (cnt == CW'(BIN_W - 1));
    bin_ext   = LW'(bin);
  end

  assign busy = (state == SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      ovf      <= 1'b0;
      lz_mask  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt      <= '0;
            ovf_pend <= (bin_ext > LIMIT);
            state    <= SHIFT;
          end
        end
        default: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            state   <= IDLE;
            done    <= 1'b1;
            bcd     <= final_bcd;
            ovf     <= ovf_pend;
            lz_mask <= blank_mask(final_bcd);
          end
        end
      endcase
    end
  end

  // Shift register is pure data; stale contents are harmless once state is IDLE.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) sr <= {{BW{1'b0}}, bin};
    else if (state == SHIFT)    sr <= sr_next;
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: default (14b/4 digits) and 8b/2 digits instances.
module tb_bin2bcd_seq;

  typedef struct {
    int          vin;
    logic [15:0] bcd;
    logic        ovf;
    logic [3:0]  lz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start8;
  logic [13:0] bin;
  logic [7:0]  bin8;
  logic        busy, done, ovf;
  logic [15:0] bcd;
  logic [3:0]  lz_mask;
  logic        busy8, done8, ovf8;
  logic [7:0]  bcd8;
  logic [1:0]  lz8;

  int checks = 0;
  int errors = 0;
  exp_t q4[$];
  exp_t q8[$];

  always #5 clk = ~clk;

  bin2bcd_seq dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin), .busy(busy), .done(done),
    .bcd(bcd), .ovf(ovf), .lz_mask(lz_mask)
  );

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .bin(bin8), .busy(busy8), .done(done8),
    .bcd(bcd8), .ovf(ovf8), .lz_mask(lz8)
  );

  function automatic exp_t model(input int v, input int nd);
    exp_t e;
    int   lim, val;
    logic allz;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    lim   = lim - 1;
    e.vin = v;
    e.ovf = (v > lim);
    e.bcd = '0;
    e.lz  = '0;
    val   = e.ovf ? lim : v;
    for (int i = 0; i < nd; i++) begin
      e.bcd[4*i +: 4] = 4'(val % 10);
      val = val / 10;
    end
    allz = 1'b1;
    for (int i = nd - 1; i >= 1; i--) begin
      allz    = allz && (e.bcd[4*i +: 4] == 4'd0);
      e.lz[i] = allz;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL done4_spurious: done with no accepted start, bcd=%h", bcd);
      end else begin
        exp_t e;
        e = q4.pop_front();
        if (bcd !== e.bcd || ovf !== e.ovf || lz_mask !== e.lz) begin
          errors++;
          $display("FAIL result4 bin=%0d: got bcd=%h ovf=%b lz=%b, expected bcd=%h ovf=%b lz=%b",
                   e.vin, bcd, ovf, lz_mask, e.bcd, e.ovf, e.lz);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done8) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL done8_spurious: done with no accepted start, bcd=%h", bcd8);
      end else begin
        exp_t e;
        e = q8.pop_front();
        if (bcd8 !== e.bcd[7:0] || ovf8 !== e.ovf || lz8 !== e.lz[1:0]) begin
          errors++;
          $display("FAIL result8 bin=%0d: got bcd=%h ovf=%b lz=%b, expected bcd=%h ovf=%b lz=%b",
                   e.vin, bcd8, ovf8, lz8, e.bcd[7:0], e.ovf, e.lz[1:0]);
        end
      end
    end
  end

  // Stimulus helpers: called at a negedge, return at the negedge after the start edge.
  task automatic issue4(input int v);
    int n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    if (busy) begin
      errors++;
      $display("FAIL idle4_timeout: busy=%b after %0d cycles, expected 0", busy, n);
    end
    start = 1'b1;
    bin   = 14'(v);
    q4.push_back(model(v, 4));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue8(input int v);
    int n = 0;
    while (busy8 && n < 100) begin @(negedge clk); n++; end
    if (busy8) begin
      errors++;
      $display("FAIL idle8_timeout: busy=%b after %0d cycles, expected 0", busy8, n);
    end
    start8 = 1'b1;
    bin8   = 8'(v);
    q8.push_back(model(v, 2));
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q4.size() != 0 || q8.size() != 0 || busy || busy8) && n < 200) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    checks++;
    if (q4.size() != 0 || q8.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: pending results q4=%0d q8=%0d, expected 0", name, q4.size(), q8.size());
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, bcd, ovf, lz_mask} !== 23'd0) begin
      errors++;
      $display("FAIL reset4: busy=%b done=%b bcd=%h ovf=%b lz=%b, expected all 0",
               busy, done, bcd, ovf, lz_mask);
    end
    checks++;
    if ({busy8, done8, bcd8, ovf8, lz8} !== 13'd0) begin
      errors++;
      $display("FAIL reset8: busy=%b done=%b bcd=%h ovf=%b lz=%b, expected all 0",
               busy8, done8, bcd8, ovf8, lz8);
    end
  endtask

  task automatic test_latency();
    int vals[2] = '{0, 1234};
    logic [15:0] exp_bcd[2] = '{16'h0000, 16'h1234};
    logic [3:0]  exp_lz[2]  = '{4'b1110, 4'b0000};
    for (int k = 0; k < 2; k++) begin
      int n = 0;
      issue4(vals[k]);
      while (busy && n < 40) begin n++; @(negedge clk); end
      checks++;
      if (n != 14 || done !== 1'b1) begin
        errors++;
        $display("FAIL latency bin=%0d: busy cycles=%0d done=%b, expected 14 and 1", vals[k], n, done);
      end
      checks++;
      if (bcd !== exp_bcd[k] || ovf !== 1'b0 || lz_mask !== exp_lz[k]) begin
        errors++;
        $display("FAIL value bin=%0d: bcd=%h ovf=%b lz=%b, expected %h 0 %b",
                 vals[k], bcd, ovf, lz_mask, exp_bcd[k], exp_lz[k]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse bin=%0d: done=%b a cycle later, expected 0", vals[k], done);
      end
    end
    drain("latency");
  endtask

  task automatic test_saturation();
    issue4(9999);
    issue4(10000);
    issue4(16383);
    drain("saturation");
    checks++;
    if (bcd !== 16'h9999 || ovf !== 1'b1 || lz_mask !== 4'b0000) begin
      errors++;
      $display("FAIL saturation: bcd=%h ovf=%b lz=%b, expected 9999 1 0000", bcd, ovf, lz_mask);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    issue4(42);
    repeat (5) @(negedge clk);
    start = 1'b1;
    bin   = 14'd7;
    @(negedge clk);
    start = 1'b0;
    bin   = 14'd123;
    while (!done && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (done !== 1'b1 || bcd !== 16'h0042 || lz_mask !== 4'b1100 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL ignore_busy_start: done=%b bcd=%h lz=%b ovf=%b, expected 1 0042 1100 0",
               done, bcd, lz_mask, ovf);
    end
    start = 1'b1;
    bin   = 14'd7;
    q4.push_back(model(7, 4));
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL accept_in_done: busy=%b, expected 1", busy);
    end
    drain("back_to_back");
    checks++;
    if (bcd !== 16'h0007 || lz_mask !== 4'b1110) begin
      errors++;
      $display("FAIL back_to_back: bcd=%h lz=%b, expected 0007 1110", bcd, lz_mask);
    end
  endtask

  task automatic test_reset_midway();
    int dones = 0;
    issue4(5000);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, bcd, ovf, lz_mask} !== 23'd0) begin
      errors++;
      $display("FAIL reset_midway: busy=%b done=%b bcd=%h ovf=%b lz=%b, expected all 0",
               busy, done, bcd, ovf, lz_mask);
    end
    q4.delete();
    rst = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones != 0 || bcd !== 16'h0000) begin
      errors++;
      $display("FAIL reset_no_done: dones=%0d bcd=%h, expected 0 and 0000", dones, bcd);
    end
  endtask

  task automatic test_sweep();
    int edge_vals[8] = '{99, 100, 999, 1000, 9998, 9999, 10000, 16383};
    for (int v = 0; v < 1000; v++) issue4(v);
    foreach (edge_vals[k]) issue4(edge_vals[k]);
    for (int v = 9990; v <= 10010; v++) issue4(v);
    for (int v = 16370; v <= 16383; v++) issue4(v);
    repeat (300) issue4(int'($urandom_range(16383, 0)));
    drain("sweep4");
    for (int v = 0; v < 256; v++) issue8(v);
    drain("sweep8");
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    start8 = 1'b0;
    bin    = '0;
    bin8   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_latency();
    test_saturation();
    test_back_to_back();
    test_reset_midway();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
